// File: rtl/rrv64_l2_refill_arb.sv
// Round-robin arbiter sharing the L2->SCU AXI read channel among MSHRs; one 4-beat INCR refill burst at a time, 512b line returned to the owner.
// Latency: req_valid to arvalid 1 cycle; rlast (or 4th) beat to resp_valid 1 cycle.
// Backpressure: arvalid/araddr held until arready; rready only in DATA; resp fields held until resp_ready.
module rrv64_l2_refill_arb #(
   parameter int REQ_N  = 4,
   parameter int IDX_W  = 2,
   parameter int ADDR_W = 56,
   parameter int BEAT_W = 128,
   parameter int LINE_W = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [REQ_N-1:0]        req_valid,
   input  logic [REQ_N*ADDR_W-1:0] req_addr,
   output logic [REQ_N-1:0]        req_gnt,
   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_W-1:0]       araddr,
   output logic [IDX_W-1:0]        arid,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic [BEAT_W-1:0]       rdata,
   input  logic [IDX_W-1:0]        rid,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [IDX_W-1:0]        resp_idx,
   output logic [LINE_W-1:0]       resp_line,
   output logic                    resp_err
);

   localparam int NBEAT  = LINE_W / BEAT_W;
   localparam int BCNT_W = $clog2(NBEAT);
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_AR,
      S_DATA,
      S_RESP
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    rr_ptr;
   logic [IDX_W-1:0]    idx;
   logic [ADDR_W-1:0]   addr;
   logic [BCNT_W-1:0]   beat_cnt;
   logic [LINE_W-1:0]   line;
   logic                err;

   logic                pick_vld;
   logic [IDX_W-1:0]    pick_idx;
   logic [IDX_W-1:0]    cand;
   logic                last_beat;

   assign last_beat = (beat_cnt == BCNT_W'(NBEAT - 1));

   // Round-robin pick: first pending requester at or after rr_ptr. The pointer
   // wraps by natural IDX_W overflow, so REQ_N is expected to equal 2**IDX_W.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = REQ_N - 1; k >= 0; k--) begin
         cand = rr_ptr + IDX_W'(k);
         if (req_valid[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Grant pulses in the AR handshake cycle for the latched requester only.
   always_comb begin
      req_gnt = '0;
      if (arvalid && arready) begin
         req_gnt[idx] = 1'b1;
      end
   end

   assign araddr    = addr & LINE_MASK;
   assign arid      = idx;
   assign arlen     = 8'(NBEAT - 1);
   assign arsize    = 3'($clog2(BEAT_W / 8));
   assign arburst   = 2'b01;
   assign resp_idx  = idx;
   assign resp_line = line;
   assign resp_err  = err;

   // Refill FSM: latch a winner, issue AR, collect beats, hand the line back.
   // The line register is not cleared between bursts, so slots missed by a
   // short burst keep their previous contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         idx        <= '0;
         addr       <= '0;
         beat_cnt   <= '0;
         line       <= '0;
         err        <= 1'b0;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         resp_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  idx     <= pick_idx;
                  addr    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                  arvalid <= 1'b1;
                  state   <= S_AR;
               end
            end
            S_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  rr_ptr  <= idx + IDX_W'(1);
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (rvalid && rready) begin
                  line[beat_cnt*BEAT_W +: BEAT_W] <= rdata;
                  beat_cnt <= beat_cnt + BCNT_W'(1);
                  err      <= err | (rresp != 2'b00) | (rid != idx) | (rlast != last_beat);
                  // Early rlast or a missing rlast both close the burst.
                  if (rlast || last_beat) begin
                     rready     <= 1'b0;
                     resp_valid <= 1'b1;
                     state      <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  err        <= 1'b0;
                  beat_cnt   <= '0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
